// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory access unit and its load path.
package mem_pkg;

    // Access size encoding as seen on req_size.
    typedef enum logic [1:0] {
        MEM_SIZE_B   = 2'b00,
        MEM_SIZE_H   = 2'b01,
        MEM_SIZE_W   = 2'b10,
        MEM_SIZE_RSV = 2'b11
    } mem_size_t;

    // Transaction state of the access unit.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_LATCH  = 2'b10,
        ST_RESP   = 2'b11
    } mem_state_t;

    // True when the size/offset pair cannot be served as a single RAM access:
    // halves must be 2-byte aligned, words 4-byte aligned, and the reserved
    // size is never legal.
    function automatic logic mem_misaligned(input mem_size_t size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            MEM_SIZE_B:   bad = 1'b0;
            MEM_SIZE_H:   bad = offset[0];
            MEM_SIZE_W:   bad = (offset != 2'b00);
            default:      bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extender.sv
// Lane shift plus sign/zero extension of a RAM read word into load data.
module load_extender
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  mem_size_t   i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_result
);

    logic [31:0] w_shifted;

    // Bring the addressed lane down to bit 0, then extend from the size's top bit.
    always_comb begin
        w_shifted = i_word >> {i_offset, 3'b000};
        o_result  = w_shifted;
        case (i_size)
            MEM_SIZE_B: o_result = i_unsigned ? {24'd0, w_shifted[7:0]}
                                              : {{24{w_shifted[7]}}, w_shifted[7:0]};
            MEM_SIZE_H: o_result = i_unsigned ? {16'd0, w_shifted[15:0]}
                                              : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default:    o_result = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store adapter between the CPU handshake and a byte-masked,
// synchronous-read RAM; one transaction in flight at a time.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 ram_wr,
    output logic [3:0]           ram_wr_mask,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [31:0]          ram_data_in,
    input  logic [31:0]          ram_data_out
);

    localparam int unsigned BYTE_ADDR_BITS = ADDR_BITS + 2;

    mem_state_t                r_state;
    mem_state_t                w_next_state;

    logic                      r_we;
    mem_size_t                 r_size;
    logic                      r_unsigned;
    logic [BYTE_ADDR_BITS-1:0] r_addr;
    logic [31:0]               r_wdata;

    logic [31:0]               r_rdata;
    logic                      r_err;

    mem_size_t                 w_req_size;
    logic                      w_accept;
    logic                      w_illegal;
    logic [31:0]               w_load_data;

    assign w_req_size = mem_size_t'(req_size);
    assign w_accept   = (r_state == ST_IDLE) && req_valid;
    assign w_illegal  = mem_misaligned(w_req_size, req_addr[1:0])
                        || ((req_addr >> BYTE_ADDR_BITS) != 32'd0);

    load_extender u_load_extender (
        .i_word     (ram_data_out),
        .i_offset   (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_result   (w_load_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; illegal requests skip the RAM and respond at once.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid) w_next_state = w_illegal ? ST_RESP : ST_ACCESS;
            ST_ACCESS: w_next_state = r_we ? ST_RESP : ST_LATCH;
            ST_LATCH:  w_next_state = ST_RESP;
            ST_RESP:   if (rsp_ready) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Capture the request on acceptance; RAM-side outputs come only from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_size     <= MEM_SIZE_B;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (w_accept) begin
            r_we       <= req_we;
            r_size     <= w_req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr[BYTE_ADDR_BITS-1:0];
            r_wdata    <= req_wdata;
        end
    end

    // Response registers: cleared on acceptance so stores/errors return zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= '0;
            r_err   <= w_illegal;
        end else if (r_state == ST_LATCH) begin
            r_rdata <= w_load_data;
        end
    end

    // Write strobe and lane mask decode from state so reset drops them at once.
    always_comb begin
        ram_wr      = 1'b0;
        ram_wr_mask = '0;
        if ((r_state == ST_ACCESS) && r_we) begin
            ram_wr = 1'b1;
            case (r_size)
                MEM_SIZE_B: ram_wr_mask = 4'b0001 << r_addr[1:0];
                MEM_SIZE_H: ram_wr_mask = 4'b0011 << r_addr[1:0];
                default:    ram_wr_mask = 4'b1111;
            endcase
        end
    end

    // Replicate store data across lanes so the mask alone selects the bytes.
    always_comb begin
        ram_data_in = r_wdata;
        case (r_size)
            MEM_SIZE_B: ram_data_in = {4{r_wdata[7:0]}};
            MEM_SIZE_H: ram_data_in = {2{r_wdata[15:0]}};
            default:    ram_data_in = r_wdata;
        endcase
    end

    assign ram_addr  = r_addr[BYTE_ADDR_BITS-1:2];
    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural RAM.
module tb_mem_access_unit;

    localparam int unsigned AB = 10;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          ram_wr;
    logic [3:0]    ram_wr_mask;
    logic [AB-1:0] ram_addr;
    logic [31:0]   ram_data_in;
    logic [31:0]   ram_data_out;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;

    logic [31:0] ram_mem [0:(1<<AB)-1];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] din;
        logic [31:0] rdata;
    } op_t;

    mem_access_unit #(.ADDR_BITS(AB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_wr       (ram_wr),
        .ram_wr_mask  (ram_wr_mask),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-masked RAM with one-cycle synchronous read.
    always @(posedge clk) begin
        if (ram_wr) begin
            wr_count <= wr_count + 1;
            for (int b = 0; b < 4; b++) begin
                if (ram_wr_mask[b]) ram_mem[ram_addr][8*b +: 8] <= ram_data_in[8*b +: 8];
            end
        end
        ram_data_out <= ram_mem[ram_addr];
    end

    // Present a request and return #1 after the edge that accepts it.
    task automatic accept(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
            $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
            $fatal(1);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b1; req_size = 2'b11;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
    endtask

    // Take the held response on the next edge.
    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b required 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h required 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b required 0", rsp_err); end
        checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL rst_ram_wr: got %b required 0", ram_wr); end
        checks++; if (ram_wr_mask !== 4'h0) begin errors++; $display("FAIL rst_ram_wr_mask: got %b required 0000", ram_wr_mask); end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_store_load();
        accept(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        checks++; if (ram_wr !== 1'b1) begin errors++; $display("FAIL ws_ram_wr: got %b required 1", ram_wr); end
        checks++; if (ram_addr !== 10'd4) begin errors++; $display("FAIL ws_ram_addr: got %0d required 4", ram_addr); end
        checks++; if (ram_wr_mask !== 4'b1111) begin errors++; $display("FAIL ws_mask: got %b required 1111", ram_wr_mask); end
        checks++; if (ram_data_in !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ws_din: got %h required deadbeef", ram_data_in); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ws_early_valid: got %b required 0", rsp_valid); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0)
            begin errors++; $display("FAIL ws_rsp: got v=%b e=%b d=%h required v=1 e=0 d=0", rsp_valid, rsp_err, rsp_rdata); end
        consume();
        accept(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checks++; if (rsp_valid !== 1'b0 || ram_wr !== 1'b0) begin errors++; $display("FAIL wl_access: got v=%b wr=%b required 0 0", rsp_valid, ram_wr); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || ram_addr !== 10'd4) begin errors++; $display("FAIL wl_latch: got v=%b addr=%0d required 0 4", rsp_valid, ram_addr); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF)
            begin errors++; $display("FAIL wl_rsp: got v=%b e=%b d=%h required v=1 e=0 d=deadbeef", rsp_valid, rsp_err, rsp_rdata); end
        consume();
    endtask

    task automatic test_byte_half();
        op_t ops [11];
        ops[0]  = '{1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFF_FFA5, 4'b1000, 32'hA5A5_A5A5, 32'h0};
        ops[1]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 4'b0000, 32'h0, 32'hFFFF_FFA5};
        ops[2]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 4'b0000, 32'h0, 32'h0000_00A5};
        ops[3]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 4'b0000, 32'h0, 32'hA5AD_BEEF};
        ops[4]  = '{1'b1, 2'b01, 1'b0, 32'h12, 32'hCAFE_8001, 4'b1100, 32'h8001_8001, 32'h0};
        ops[5]  = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 4'b0000, 32'h0, 32'hFFFF_8001};
        ops[6]  = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 4'b0000, 32'h0, 32'h0000_8001};
        ops[7]  = '{1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 4'b0000, 32'h0, 32'hFFFF_FFEF};
        ops[8]  = '{1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 4'b0000, 32'h0, 32'h0000_00BE};
        ops[9]  = '{1'b1, 2'b00, 1'b0, 32'h11, 32'h1234_567C, 4'b0010, 32'h7C7C_7C7C, 32'h0};
        ops[10] = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 4'b0000, 32'h0, 32'h0000_7CEF};
        for (int i = 0; i < 11; i++) begin
            accept(ops[i].we, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata);
            checks++; if (ram_wr !== ops[i].we) begin errors++; $display("FAIL bh%0d_ram_wr: got %b required %b", i, ram_wr, ops[i].we); end
            if (ops[i].we) begin
                checks++; if (ram_wr_mask !== ops[i].mask) begin errors++; $display("FAIL bh%0d_mask: got %b required %b", i, ram_wr_mask, ops[i].mask); end
                checks++; if (ram_data_in !== ops[i].din) begin errors++; $display("FAIL bh%0d_din: got %h required %h", i, ram_data_in, ops[i].din); end
                @(posedge clk); #1;
            end else begin
                @(posedge clk); #1;
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bh%0d_latch_valid: got %b required 0", i, rsp_valid); end
                @(posedge clk); #1;
            end
            checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== ops[i].rdata)
                begin errors++; $display("FAIL bh%0d_rsp: got v=%b e=%b d=%h required v=1 e=0 d=%h", i, rsp_valid, rsp_err, rsp_rdata, ops[i].rdata); end
            consume();
        end
    endtask

    task automatic test_errors();
        logic        we   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  size [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
        logic [31:0] addr [4] = '{32'h11, 32'h02, 32'h00, 32'h1000};
        int wr_before;
        wr_before = wr_count;
        for (int i = 0; i < 4; i++) begin
            accept(we[i], size[i], 1'b0, addr[i], 32'h1111_1111);
            checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || ram_wr !== 1'b0)
                begin errors++; $display("FAIL err%0d_rsp: got v=%b e=%b d=%h wr=%b required v=1 e=1 d=0 wr=0", i, rsp_valid, rsp_err, rsp_rdata, ram_wr); end
            consume();
        end
        checks++; if (wr_count !== wr_before) begin errors++; $display("FAIL err_no_write: got %0d writes required %0d", wr_count, wr_before); end
    endtask

    task automatic test_backpressure();
        int wr_before;
        wr_before = wr_count;
        accept(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h40; req_wdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 5; c++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h8001_7CEF || rsp_err !== 1'b0 || req_ready !== 1'b0)
                begin errors++; $display("FAIL bp%0d_hold: got v=%b d=%h e=%b rdy=%b required v=1 d=80017cef e=0 rdy=0", c, rsp_valid, rsp_rdata, rsp_err, req_ready); end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        consume();
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got rdy=%b v=%b required 1 0", req_ready, rsp_valid); end
        checks++; if (wr_count !== wr_before) begin errors++; $display("FAIL bp_no_write: got %0d writes required %0d", wr_count, wr_before); end
    endtask

    task automatic test_back_to_back();
        accept(1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678);
        @(posedge clk); #1;
        consume();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: got %b required 1", req_ready); end
        accept(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        checks++; if (req_ready !== 1'b0 || ram_addr !== 10'd8) begin errors++; $display("FAIL b2b_accept: got rdy=%b addr=%0d required 0 8", req_ready, ram_addr); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL b2b_rsp: got v=%b d=%h required 1 12345678", rsp_valid, rsp_rdata); end
        consume();
    endtask

    task automatic test_reset_mid_store();
        int wr_before;
        wr_before = wr_count;
        accept(1'b1, 2'b10, 1'b0, 32'h30, 32'h5566_7788);
        checks++; if (ram_wr !== 1'b1) begin errors++; $display("FAIL rs_access_wr: got %b required 1", ram_wr); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (ram_wr !== 1'b0 || ram_wr_mask !== 4'h0) begin errors++; $display("FAIL rs_wr_drop: got wr=%b mask=%b required 0 0000", ram_wr, ram_wr_mask); end
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rs_idle: got rdy=%b v=%b required 1 0", req_ready, rsp_valid); end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rs_no_rsp: got v=%b rdy=%b required 0 1", rsp_valid, req_ready); end
        checks++; if (wr_count !== wr_before) begin errors++; $display("FAIL rs_no_write: got %0d writes required %0d", wr_count, wr_before); end
        accept(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL rs_old_data: got v=%b d=%h required 1 00000000", rsp_valid, rsp_rdata); end
        consume();
    endtask

    initial begin
        for (int i = 0; i < (1 << AB); i++) ram_mem[i] = 32'h0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        test_reset();
        test_word_store_load();
        test_byte_half();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side adapter that drives the byte-masked, word-wide, synchronous-read RAM on behalf of the CPU load/store stage. It accepts one byte/half/word load or store per transaction through a valid/ready handshake and converts the byte address into a word address, byte-lane write mask and lane-replicated write data. It absorbs the RAM's one-cycle read latency, then returns aligned, sign- or zero-extended load data or an error flag on a held response channel.

## Interface
- ADDR_BITS, 10, RAM word-address width; the addressable range is 4·2^ADDR_BITS bytes.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1 and sign-extends when 0; ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned access, reserved size, or out-of-range address.
- ram_wr  out  1  RAM write strobe.
- ram_wr_mask  out  4  RAM byte-lane enables.
- ram_addr  out  ADDR_BITS  RAM word address.
- ram_data_in  out  32  RAM write data.
- ram_data_out  in  32  RAM read data, valid one cycle after the address is presented.

## Operation
- States: IDLE, ACCESS, LATCH, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture we, size, unsigned, addr and wdata.
  - Go to RESP with the error flag set if the request is illegal; otherwise go to ACCESS.
- Illegal request:
  - half with addr[0] = 1;
  - word with addr[1:0] ≠ 0;
  - size = 11;
  - addr[31:ADDR_BITS+2] ≠ 0.
- ACCESS:
  - Drive ram_addr = addr[ADDR_BITS+1:2].
  - Store: ram_wr = 1, then go to RESP.
  - Load: ram_wr = 0, then go to LATCH.
- Write mask:
  - byte: 0001 shifted left by addr[1:0];
  - half: 0011 shifted left by addr[1:0];
  - word: 1111.
- ram_data_in:
  - byte: wdata[7:0] replicated ×4;
  - half: wdata[15:0] replicated ×2;
  - word: wdata.
- LATCH:
  - Keep ram_addr stable and ram_wr = 0.
  - Right-shift ram_data_out by 8·addr[1:0], then extend from bit 7 (byte) or bit 15 (half) per the unsigned flag.
  - Register the result into rsp_rdata, then go to RESP.
- RESP:
  - rsp_valid = 1, with rsp_rdata and rsp_err held stable.
  - On rsp_ready, go to IDLE.
- ram_wr is asserted only in ACCESS for a legal store, so an error never touches the RAM.
- ram_addr and ram_data_in outside ACCESS/LATCH are don't-care, but the implementation drives them from the captured registers (no combinational path from req_* to ram_*).

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, ram_wr 0, ram_wr_mask 0.
- ram_wr and ram_wr_mask decode from state, so they drop asynchronously with rst_n.
- Reset mid-operation returns to IDLE with no response issued. A store whose ACCESS cycle already completed stays written.
- Latency, with acceptance at edge T:
  - legal store: rsp_valid from T+2;
  - legal load: rsp_valid from T+3;
  - error: rsp_valid from T+1.
- Throughput: one transaction outstanding; req_ready = 0 from acceptance until RESP is consumed.
- Back-to-back: a request present in the cycle after rsp_valid && rsp_ready is accepted on the following edge. There is no same-cycle RESP→accept bypass.
- req_* may change freely while req_ready = 0.

## Structure
- Shared package mem_pkg:
  - size typedef with MEM_SIZE_B, MEM_SIZE_H, MEM_SIZE_W, MEM_SIZE_RSV;
  - state enum mem_state_t;
  - function for the alignment-legality check.
- Sub-module load_extender: combinational lane shift plus sign/zero extension.
  - Inputs: 32-bit word, 2-bit offset, size, unsigned flag.
  - Output: 32-bit result.
  - Reused later by the CPU's I/O path.

## Test plan
- Word store then load:
  - Store addr 0x10, wdata 0xDEADBEEF → ram_addr 4, ram_wr_mask 1111, ram_data_in 0xDEADBEEF, rsp_valid at T+2, rsp_err 0.
  - Word load from 0x10 → rsp_rdata 0xDEADBEEF at T+3.
- Byte store 0xA5 to 0x13 → ram_wr_mask 1000, ram_data_in 0xA5A5A5A5. Then:
  - signed byte load of 0x13 → 0xFFFFFFA5;
  - unsigned byte load of 0x13 → 0x000000A5;
  - word load of 0x10 → 0xA5ADBEEF.
- Half store 0x8001 to 0x12 → ram_wr_mask 1100, ram_data_in 0x80018001. Signed half load of 0x12 → 0xFFFF8001.
- Errors, each giving rsp_err 1 at T+1, ram_wr never high, rsp_rdata 0:
  - half load at 0x11;
  - word store at 0x02;
  - size 11;
  - addr 0x1000 with ADDR_BITS = 10.
- Backpressure: hold rsp_ready 0 for 5 cycles on a load → rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0. Release → IDLE next edge.
- Reset: pulse rst_n low during ACCESS of a store → ram_wr falls immediately, state IDLE, no rsp_valid. A subsequent load of that word returns either the old or the new data, consistent with whether the write edge occurred.
